receivers_readout_scheduler: RTL and testbench
==============================================

# receivers_readout_scheduler

Round-robin readout controller for NB_RECEIVERS photodiode receiver channels, each being one single-receiver pipeline: TS4231 front end, BMC decoder and decoded-block RAM. It polls every channel's available-block count, drives that channel's block-number select, waits for the RAM's data-ready, and forwards each 41-bit block tagged with its channel ID on a valid/ready stream. That stream feeds the host link serializer. A timeout keeps one stuck channel from stalling the others.

## Interface
- NB_RECEIVERS, 4: number of receiver channels; legal range 1..16.
- TIMEOUT_CYCLES, 15: cycles allowed between request and data-ready before the request is abandoned; legal range 2..255.
- clk_96MHz  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- avl_blocks_nb  in  8*NB_RECEIVERS  per-channel available-block count; channel i occupies bits [8i+7:8i].
- data_ready  in  NB_RECEIVERS  per-channel "block_wanted is valid for the current select".
- block_wanted  in  41*NB_RECEIVERS  per-channel block word (17-bit decoded data + 24-bit timestamp).
- block_wanted_number  out  8*NB_RECEIVERS  per-channel block select; 8'hFF = idle/no request.
- out_valid  out  1  out_block/out_rx_id are valid.
- out_ready  in  1  consumer accepts when out_valid && out_ready.
- out_block  out  41  forwarded block word, unmodified.
- out_rx_id  out  4  source channel index.
- timeout_count  out  8  number of abandoned requests, saturating at 255.

## Operation
- Per-channel read index rd_idx[i] (8 bit), reset 0. Channel i is eligible when avl_blocks_nb[i] > rd_idx[i].
- If avl_blocks_nb[i] < rd_idx[i], the channel's RAM has been cleared. rd_idx[i] is forced to 0 on that cycle in every state except a WAIT or OUTPUT on channel i. In those states the clear is applied when the transaction completes.
- Round-robin pointer ptr (4 bit), reset 0. The search starts at ptr and takes the first eligible channel in ascending order, wrapping at NB_RECEIVERS.
- FSM:
  - IDLE: if no channel is eligible, stay. Otherwise latch the granted channel g, go to REQ.
  - REQ, 1 cycle: drive block_wanted_number[g] = rd_idx[g], clear the timer, go to WAIT.
  - WAIT: hold the select. The first WAIT cycle ignores data_ready, because its value is stale from the previous select.
    - data_ready[g] high → capture block_wanted[g] and g into the output register, go to OUTPUT.
    - Timer reaches TIMEOUT_CYCLES → timeout_count++ (saturating), rd_idx[g]++, ptr = g+1 mod NB_RECEIVERS, go to IDLE.
  - OUTPUT: out_valid = 1. On out_ready: rd_idx[g]++, ptr = g+1 mod NB_RECEIVERS, go to IDLE.
- Non-granted channels always see 8'hFF. The granted channel sees 8'hFF in IDLE and OUTPUT.
- rd_idx never wraps past 8'hFE. If avl_blocks_nb reports 255, index 254 is the last one read.
- Only one request is outstanding at a time. There is no pipelining across channels.

## Timing
- Reset values: block_wanted_number all 8'hFF, out_valid 0, out_block 0, out_rx_id 0, timeout_count 0, FSM in IDLE.
- Eligible channel seen in IDLE at cycle 0 → select driven at cycle 1 (REQ) → first data_ready sample at cycle 3 → out_valid at cycle 4 at the earliest.
- The out_* registers are stable while out_valid && !out_ready. out_valid drops the cycle after acceptance.
- Back-to-back throughput is at best 1 block per 5 cycles.
- Reset mid-transaction: everything returns to reset values immediately. Any in-flight block is dropped and not counted as a timeout.
- Simultaneous eligibility on several channels: the lowest index ≥ ptr wins.

## Structure
- Shared package/header: select-idle constant 8'hFF, block width 41, channel-ID width 4, FSM state encodings.
- One sub-module: rr_eligible_picker. It is combinational: it takes the eligible vector and ptr and returns found plus index.
- Everything else, including FSM, per-channel indices and timer, lives in the top level.

## Test plan
- Single block on channel 0: avl_blocks_nb[0] = 1, data_ready pulses 2 cycles after the select → out_block matches the RAM word, out_rx_id = 0, block_wanted_number[0] returns to FF, rd_idx[0] = 1, no second read.
- Fairness: channels 1 and 3 each report 3 blocks, out_ready held high → output order is 1,3,1,3,1,3 with select indices 0,0,1,1,2,2.
- Backpressure: out_ready low for 20 cycles while out_valid → out_* hold constant, no new select is driven, one block is delivered when ready rises.
- Timeout: channel 2 eligible, data_ready never asserts → after TIMEOUT_CYCLES timeout_count = 1, rd_idx[2] = 1, and a pending channel 3 is served next.
- RAM clear: rd_idx[0] = 3, avl_blocks_nb[0] drops to 0 then rises to 1 → next request on channel 0 uses index 0.
- Reset during WAIT: assert reset mid-wait → all selects FF, out_valid 0, timeout_count unchanged from reset value 0; normal readout resumes after release.

Source files
------------

// File: rtl/receivers_readout_scheduler_pkg.sv
// rtl/receivers_readout_scheduler_pkg.sv - shared constants and FSM encoding for the receiver readout scheduler
package receivers_readout_scheduler_pkg;

    localparam logic [7:0] SEL_IDLE = 8'hFF;
    localparam int         BLOCK_W  = 41;
    localparam int         RX_ID_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT   = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

endpackage

// File: rtl/receivers_readout_scheduler_rr_eligible_picker.sv
// rtl/receivers_readout_scheduler_rr_eligible_picker.sv - round-robin first-eligible channel search
// eligible : per-channel request vector
// ptr      : search start channel (always < N)
// found    : at least one channel eligible
// idx      : first eligible channel at or after ptr, wrapping at N
module rr_eligible_picker
    import receivers_readout_scheduler_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]       eligible,
    input  logic [RX_ID_W-1:0] ptr,
    output logic               found,
    output logic [RX_ID_W-1:0] idx
);

    // Two descending passes: the last assignment wins, so the second pass
    // (channels >= ptr) overrides the wrapped pass (channels < ptr), and
    // within each pass the lowest index wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int c = N - 1; c >= 0; c--) begin
            if (eligible[c] && (RX_ID_W'(c) < ptr)) begin
                found = 1'b1;
                idx   = RX_ID_W'(c);
            end
        end
        for (int c = N - 1; c >= 0; c--) begin
            if (eligible[c] && (RX_ID_W'(c) >= ptr)) begin
                found = 1'b1;
                idx   = RX_ID_W'(c);
            end
        end
    end

endmodule

// File: rtl/receivers_readout_scheduler.sv
// rtl/receivers_readout_scheduler.sv - round-robin block readout from per-channel decoded-block RAMs
// clk_96MHz, reset      : clock, async active-high reset
// avl_blocks_nb         : per-channel available block count (8 bits each)
// data_ready            : per-channel RAM word valid for current select
// block_wanted          : per-channel RAM word (41 bits each)
// block_wanted_number   : per-channel block select, 8'hFF when idle
// out_valid/out_ready   : output stream handshake
// out_block, out_rx_id  : forwarded word and its source channel
// timeout_count         : saturating count of abandoned requests
module receivers_readout_scheduler
    import receivers_readout_scheduler_pkg::*;
#(
    parameter int NB_RECEIVERS   = 4,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                          clk_96MHz,
    input  logic                          reset,
    input  logic [8*NB_RECEIVERS-1:0]     avl_blocks_nb,
    input  logic [NB_RECEIVERS-1:0]       data_ready,
    input  logic [BLOCK_W*NB_RECEIVERS-1:0] block_wanted,
    output logic [8*NB_RECEIVERS-1:0]     block_wanted_number,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [BLOCK_W-1:0]            out_block,
    output logic [RX_ID_W-1:0]            out_rx_id,
    output logic [7:0]                    timeout_count
);

    state_t               state, state_next;
    logic [RX_ID_W-1:0]   grant, ptr;
    logic [7:0]           rd_idx [NB_RECEIVERS];
    logic [7:0]           timer;
    logic [NB_RECEIVERS-1:0] eligible, cleared;
    logic                 pick_found;
    logic [RX_ID_W-1:0]   pick_idx;
    logic                 dr_g;
    logic [BLOCK_W-1:0]   blk_g;
    logic                 got_data, timed_out, accepted, done;

    always_comb begin
        for (int i = 0; i < NB_RECEIVERS; i++) begin
            eligible[i] = avl_blocks_nb[8*i +: 8] > rd_idx[i];
            cleared[i]  = avl_blocks_nb[8*i +: 8] < rd_idx[i];
        end
    end

    rr_eligible_picker #(.N(NB_RECEIVERS)) u_picker (
        .eligible (eligible),
        .ptr      (ptr),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    always_comb begin
        dr_g  = 1'b0;
        blk_g = '0;
        for (int i = 0; i < NB_RECEIVERS; i++) begin
            if (grant == RX_ID_W'(i)) begin
                dr_g  = data_ready[i];
                blk_g = block_wanted[BLOCK_W*i +: BLOCK_W];
            end
        end
    end

    // timer == 0 marks the first WAIT cycle, where data_ready still reflects
    // the previous select and must be ignored.
    assign got_data  = (state == ST_WAIT) && (timer != 8'd0) && dr_g;
    assign timed_out = (state == ST_WAIT) && !got_data && (timer == 8'(TIMEOUT_CYCLES - 1));
    assign accepted  = (state == ST_OUTPUT) && out_ready;
    assign done      = timed_out || accepted;

    always_comb begin
        state_next          = state;
        out_valid           = 1'b0;
        block_wanted_number = {NB_RECEIVERS{SEL_IDLE}};
        case (state)
            ST_IDLE:   if (pick_found) state_next = ST_REQ;
            ST_REQ:    state_next = ST_WAIT;
            ST_WAIT: begin
                if (got_data)       state_next = ST_OUTPUT;
                else if (timed_out) state_next = ST_IDLE;
            end
            ST_OUTPUT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = ST_IDLE;
            end
            default:   state_next = ST_IDLE;
        endcase
        if (state == ST_REQ || state == ST_WAIT) begin
            for (int i = 0; i < NB_RECEIVERS; i++) begin
                if (grant == RX_ID_W'(i)) block_wanted_number[8*i +: 8] = rd_idx[i];
            end
        end
    end

    always_ff @(posedge clk_96MHz or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            grant         <= '0;
            ptr           <= '0;
            timer         <= 8'd0;
            out_block     <= '0;
            out_rx_id     <= '0;
            timeout_count <= 8'd0;
            for (int i = 0; i < NB_RECEIVERS; i++) rd_idx[i] <= 8'd0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && pick_found) grant <= pick_idx;

            if (state == ST_REQ)       timer <= 8'd0;
            else if (state == ST_WAIT) timer <= timer + 8'd1;

            if (got_data) begin
                out_block <= blk_g;
                out_rx_id <= grant;
            end

            if (timed_out && timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;

            if (done) ptr <= (grant == RX_ID_W'(NB_RECEIVERS - 1)) ? '0 : grant + 1'b1;

            // A RAM clear on the channel being served is deferred to the end of
            // its transaction so the select stays stable while the RAM answers.
            // The index stops at 8'hFF, which no count can exceed, so the last
            // block read is 254.
            for (int i = 0; i < NB_RECEIVERS; i++) begin
                if (done && grant == RX_ID_W'(i)) begin
                    if (cleared[i])              rd_idx[i] <= 8'd0;
                    else if (rd_idx[i] != 8'hFF) rd_idx[i] <= rd_idx[i] + 8'd1;
                end else if (cleared[i] &&
                             !((state == ST_WAIT || state == ST_OUTPUT) && grant == RX_ID_W'(i))) begin
                    rd_idx[i] <= 8'd0;
                end
            end
        end
    end

endmodule

// File: tb/tb_receivers_readout_scheduler.sv
// tb/tb_receivers_readout_scheduler.sv - directed self-checking bench for receivers_readout_scheduler
module tb_receivers_readout_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] avl_blocks_nb;
    logic [3:0]  data_ready;
    logic [163:0] block_wanted;
    logic [31:0] block_wanted_number;
    logic        out_valid;
    logic        out_ready;
    logic [40:0] out_block;
    logic [3:0]  out_rx_id;
    logic [7:0]  timeout_count;
    logic [3:0]  dr_en;
    logic [7:0]  d1 [4];
    logic [7:0]  d2 [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    receivers_readout_scheduler #(.NB_RECEIVERS(4), .TIMEOUT_CYCLES(15)) dut (
        .clk_96MHz           (clk),
        .reset               (reset),
        .avl_blocks_nb       (avl_blocks_nb),
        .data_ready          (data_ready),
        .block_wanted        (block_wanted),
        .block_wanted_number (block_wanted_number),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_block           (out_block),
        .out_rx_id           (out_rx_id),
        .timeout_count       (timeout_count)
    );

    function automatic logic [40:0] word(input int ch, input logic [7:0] idx);
        return {1'b1, 4'(ch), idx, 28'h5A5A5A5 ^ {20'h0, idx}};
    endfunction

    // RAM model: word follows the select, data_ready rises once the select
    // has been held for two cycles.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            d1[i] <= reset ? 8'hFF : block_wanted_number[8*i +: 8];
            d2[i] <= reset ? 8'hFF : d1[i];
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_ram
        assign block_wanted[41*g +: 41] = word(g, block_wanted_number[8*g +: 8]);
        assign data_ready[g] = dr_en[g] && (block_wanted_number[8*g +: 8] != 8'hFF) &&
                               (d2[g] == block_wanted_number[8*g +: 8]);
    end

    function automatic logic [7:0] sel_of(input int ch);
        return block_wanted_number[8*ch +: 8];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_avl(input int ch, input logic [7:0] v);
        avl_blocks_nb[8*ch +: 8] = v;
    endtask

    task automatic serve(input int ch, input logic [7:0] idx);
        int n;
        n = 0;
        while (sel_of(ch) == 8'hFF && n < 60) begin tick(); n++; end
        chk("sel_idx", sel_of(ch), idx);
        n = 0;
        while (!out_valid && n < 60) begin tick(); n++; end
        chk("sel_to_valid_cycles", n, 3);
        chk("out_rx_id", out_rx_id, ch);
        chk("out_block", out_block, word(ch, idx));
        if (out_ready) tick();
    endtask

    initial begin
        reset         = 1'b1;
        avl_blocks_nb = '0;
        out_ready     = 1'b0;
        dr_en         = 4'hF;
        repeat (3) tick();
        chk("rst_sel", block_wanted_number, {4{8'hFF}});
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_block", out_block, 41'd0);
        chk("rst_rx_id", out_rx_id, 4'd0);
        chk("rst_timeouts", timeout_count, 8'd0);
        reset = 1'b0;
        tick();

        // single block on channel 0
        out_ready = 1'b1;
        set_avl(0, 8'd1);
        serve(0, 8'd0);
        chk("single_after_valid", out_valid, 1'b0);
        chk("single_after_sel", block_wanted_number, {4{8'hFF}});
        repeat (10) tick();
        chk("single_no_reread", {out_valid, block_wanted_number}, {1'b0, {4{8'hFF}}});

        // fairness between channels 1 and 3
        set_avl(1, 8'd3);
        set_avl(3, 8'd3);
        for (int k = 0; k < 3; k++) begin
            serve(1, 8'(k));
            serve(3, 8'(k));
        end

        // backpressure
        out_ready = 1'b0;
        set_avl(1, 8'd4);
        serve(1, 8'd3);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("bp_hold", {out_valid, out_rx_id, out_block, block_wanted_number},
                {1'b1, 4'd1, word(1, 8'd3), {4{8'hFF}}});
        end
        out_ready = 1'b1;
        tick();
        chk("bp_released", out_valid, 1'b0);
        repeat (5) tick();
        chk("bp_single_delivery", out_valid, 1'b0);

        // timeout on channel 2, channel 3 pending
        dr_en[2] = 1'b0;
        set_avl(2, 8'd1);
        set_avl(3, 8'd4);
        for (int n = 0; n < 20 && sel_of(2) == 8'hFF; n++) tick();
        chk("to_sel", sel_of(2), 8'd0);
        chk("to_other_idle", sel_of(3), 8'hFF);
        repeat (15) tick();
        chk("to_last_wait", {timeout_count, sel_of(2)}, {8'd0, 8'd0});
        tick();
        chk("to_count", timeout_count, 8'd1);
        chk("to_sel_released", sel_of(2), 8'hFF);
        serve(3, 8'd3);
        repeat (10) tick();
        chk("to_idx_advanced", sel_of(2), 8'hFF);
        dr_en[2] = 1'b1;
        set_avl(2, 8'd2);
        serve(2, 8'd1);

        // RAM clear on channel 0
        set_avl(0, 8'd3);
        serve(0, 8'd1);
        serve(0, 8'd2);
        set_avl(0, 8'd0);
        repeat (2) tick();
        chk("clr_idle", sel_of(0), 8'hFF);
        set_avl(0, 8'd1);
        serve(0, 8'd0);

        // reset during WAIT
        dr_en[0] = 1'b0;
        set_avl(0, 8'd2);
        for (int n = 0; n < 20 && sel_of(0) == 8'hFF; n++) tick();
        chk("rw_sel", sel_of(0), 8'd1);
        repeat (3) tick();
        chk("rw_pre_timeouts", timeout_count, 8'd1);
        reset = 1'b1;
        #1;
        chk("rw_sel_idle", block_wanted_number, {4{8'hFF}});
        chk("rw_valid", out_valid, 1'b0);
        chk("rw_timeouts", timeout_count, 8'd0);
        repeat (2) tick();
        avl_blocks_nb = '0;
        dr_en = 4'hF;
        reset = 1'b0;
        repeat (5) tick();
        chk("rw_quiet", {out_valid, block_wanted_number}, {1'b0, {4{8'hFF}}});
        set_avl(1, 8'd1);
        serve(1, 8'd0);
        chk("rw_final_timeouts", timeout_count, 8'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
